pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
Pipelined successor to the single-cycle decoder. Decodes the ID-stage MIPS instruction and registers the control bundle into the ID/EX boundary. Also owns load-use hazard stalls, branch flush, external memory-wait hold, and the undefined-instruction halt. It sits between the IF/ID register and the EX stage, and drives the PC and IF/ID write enables.

Parameters:
INST_W, 32, instruction width; opcode is always [INST_W-1:INST_W-6].
REG_AW, 5, register-address width.
LU_STALLS, 1, bubbles inserted per load-use hazard (legal 1..3).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
id_inst  in  INST_W  instruction in ID
id_valid  in  1  id_inst holds a real instruction
branch_taken  in  1  EX resolved a taken branch or jump; flush
ex_stall_in  in  1  memory wait; freeze the front end
undef_clr  in  1  clears the HALT state
pc_we  out  1  PC write enable (combinational)
ifid_we  out  1  IF/ID write enable (combinational)
ifid_flush  out  1  zero IF/ID (combinational, equals branch_taken)
ex_valid  out  1  EX holds a real instruction
ex_reg_write, ex_alu_src, ex_reg_dst, ex_mem_w, ex_mem_r, ex_mem_to_reg, ex_jump  out  1 each  registered controls
ex_alu_op  out  2  00 R-type/funct, 01 add, 10 or
ex_branch  out  2  bit0 = branch, bit1 = 1 for bne
ex_wreg  out  REG_AW  destination: rd for R-type, 31 for jal, rt otherwise
undef_inst  out  1  sticky undefined-opcode flag
undef_opcode  out  6  opcode of the first undefined instruction

Behaviour:
- Reset (rst_n = 0 at an edge):
  - all ex_* outputs, undef_inst and undef_opcode go to 0; state RUN; counter 0.
  - pc_we and ifid_we are 0 while rst_n = 0.
- Decode table (all don't-cares resolved to 0):
  - R-type 000000: rw=1, reg_dst=1, alu_op=00.
  - addi 001000: rw, alu_src, alu_op=01.
  - ori 001101: rw, alu_src, alu_op=10.
  - lw 100011 and IN 100100: rw, alu_src, alu_op=01, mem_r, mem_to_reg.
  - sw 101011 and OUT 101100: alu_src, alu_op=01, mem_w.
  - beq 000100: branch=01. bne 000101: branch=11.
  - j 000010: jump. jal 000011: jump, rw, wreg=31.
  - Any other opcode is undefined.
- Latency: one cycle, ID decode to ex_* outputs.
- Source registers used:
  - rs: every opcode except j and jal.
  - rt: R-type, beq, bne, sw, OUT.
- Load-use hazard:
  - Condition: ex_valid, ex_mem_r, ex_wreg ≠ 0, and ex_wreg equals a used source of a valid id_inst.
  - Response: pc_we = ifid_we = 0, a bubble is loaded into EX (ex_valid = 0, all controls 0), and the FSM enters LU_STALL with counter = LU_STALLS-1.
  - In LU_STALL, bubbles continue and the counter decrements each cycle. Return to RUN when the counter reaches 0.
  - The comparison uses EX-stage fields latched at hazard detection. The comparison is not re-evaluated inside LU_STALL.
- States: RUN, LU_STALL, HALT.
- Priority, highest first: reset > branch_taken > ex_stall_in > HALT > load-use > normal decode.
  - branch_taken: ifid_flush = 1, PC written, EX loaded with a bubble, counter cleared, state RUN. Does not exit HALT.
  - ex_stall_in: all ex_* registers, counter and state hold; pc_we = ifid_we = 0.
  - HALT: pc_we = ifid_we = 0, EX gets bubbles. undef_clr returns to RUN on the next edge.
  - Normal decode: pc_we = ifid_we = 1.
- Undefined opcode (id_valid = 1, RUN, no higher-priority event):
  - A bubble is loaded into EX, undef_inst is set, undef_opcode is captured if undef_inst was 0, and the FSM goes to HALT.
  - undef_opcode holds until undef_clr; undef_clr then zeroes undef_inst and undef_opcode.
- id_valid = 0: a bubble is loaded into EX; no hazard is evaluated.
- Reset during LU_STALL or HALT has reset behaviour and overrides everything.

Decomposition:
- Shared package (mips_pkg): the opcode localparams (OP_RTYPE, OP_ADDI, …, OP_OUT), the ALU_OP encodings, and the ctrl bundle struct/width constant.
- One sub-module: ctrl_decode, purely combinational. Maps opcode to {bundle, uses_rs, uses_rt, undef}.
- pipe_ctrl_unit holds the FSM, the counter and the ID/EX registers.

Test Plan:
- Reset then lw 0x8C220004 (rt=2) -> next cycle: ex_valid=1, reg_write=1, alu_src=1, alu_op=01, mem_r=1, mem_to_reg=1, wreg=2.
- lw $2, then add $3,$2,$4 back-to-back, LU_STALLS=1 -> one cycle with pc_we=0, ifid_we=0, ex_valid=0; next cycle the add is in EX with reg_dst=1, wreg=3.
- Same sequence, LU_STALLS=3 -> three bubbles. Then repeat with wreg=0: no stall.
- beq in EX, branch_taken=1 during a load-use stall -> ifid_flush=1, pc_we=1, bubble in EX, state RUN, ex_branch is 00 next cycle.
- Opcode 111111 -> undef_inst=1, undef_opcode=6'h3F, pc_we=0 indefinitely. A second undefined opcode leaves undef_opcode unchanged. undef_clr -> RUN, flags 0.
- ex_stall_in=1 for 4 cycles mid-LU_STALL -> ex_* and the counter frozen, pc_we=0. The stall resumes its remaining count after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Opcode map, ALU-op encodings and the ID/EX control bundle shared by the control unit.
// Purely declarative; no latency or flow control of its own.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_IN    = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_OUT   = 6'b101100;

    localparam logic [1:0] ALU_FUNCT = 2'b00;
    localparam logic [1:0] ALU_ADD   = 2'b01;
    localparam logic [1:0] ALU_OR    = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_w;
        logic       mem_r;
        logic       mem_to_reg;
        logic       jump;
        logic [1:0] alu_op;
        logic [1:0] branch;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to control bundle, source-register usage and undefined flag.
// Combinational, zero latency; no flow control.
module ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    output ctrl_t      o_ctrl,
    output logic       o_uses_rs,
    output logic       o_uses_rt,
    output logic       o_undef
);

    always_comb begin
        o_ctrl    = '0;
        o_uses_rs = 1'b1;
        o_uses_rt = 1'b0;
        o_undef   = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.alu_op    = ALU_FUNCT;
                o_uses_rt        = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = ALU_ADD;
            end
            OP_ORI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = ALU_OR;
            end
            OP_LW, OP_IN: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.alu_op     = ALU_ADD;
                o_ctrl.mem_r      = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            OP_SW, OP_OUT: begin
                o_ctrl.alu_src = 1'b1;
                o_ctrl.alu_op  = ALU_ADD;
                o_ctrl.mem_w   = 1'b1;
                o_uses_rt      = 1'b1;
            end
            OP_BEQ: begin
                o_ctrl.branch = 2'b01;
                o_uses_rt     = 1'b1;
            end
            OP_BNE: begin
                o_ctrl.branch = 2'b11;
                o_uses_rt     = 1'b1;
            end
            OP_J: begin
                o_ctrl.jump = 1'b1;
                o_uses_rs   = 1'b0;
            end
            OP_JAL: begin
                o_ctrl.jump      = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_uses_rs        = 1'b0;
            end
            default: o_undef = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage decode into the ID/EX register plus load-use stall, flush, memory-wait hold and undefined halt.
// One cycle ID to EX; pc_we/ifid_we drop combinationally whenever the front end must hold.
module pipe_ctrl_unit
    import mips_pkg::*;
#(
    parameter int INST_W    = 32,
    parameter int REG_AW    = 5,
    parameter int LU_STALLS = 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] id_inst,
    input  logic              id_valid,
    input  logic              branch_taken,
    input  logic              ex_stall_in,
    input  logic              undef_clr,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic              ex_mem_w,
    output logic              ex_mem_r,
    output logic              ex_mem_to_reg,
    output logic              ex_jump,
    output logic [1:0]        ex_alu_op,
    output logic [1:0]        ex_branch,
    output logic [REG_AW-1:0] ex_wreg,
    output logic              undef_inst,
    output logic [5:0]        undef_opcode
);

    typedef enum logic [1:0] {ST_RUN, ST_LU_STALL, ST_HALT} state_t;

    localparam int              CNT_W     = 2;
    localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LU_STALLS - 1);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    ctrl_t             r_ex, w_ex_nxt;
    logic              r_ex_valid, w_ex_valid_nxt;
    logic [REG_AW-1:0] r_wreg, w_wreg_nxt;
    logic              r_undef, w_undef_nxt;
    logic [5:0]        r_undef_op, w_undef_op_nxt;
    logic              w_we, w_bubble;

    logic [5:0]        w_opcode;
    logic [REG_AW-1:0] w_rs, w_rt, w_rd, w_dec_wreg;
    ctrl_t             w_dec;
    logic              w_uses_rs, w_uses_rt, w_undef_op, w_hazard;
    logic              w_unused_low;

    assign w_opcode     = id_inst[INST_W-1 -: 6];
    assign w_rs         = id_inst[INST_W-7 -: REG_AW];
    assign w_rt         = id_inst[INST_W-7-REG_AW -: REG_AW];
    assign w_rd         = id_inst[INST_W-7-2*REG_AW -: REG_AW];
    assign w_unused_low = ^id_inst[INST_W-7-3*REG_AW:0];

    ctrl_decode u_dec (
        .i_opcode  (w_opcode),
        .o_ctrl    (w_dec),
        .o_uses_rs (w_uses_rs),
        .o_uses_rt (w_uses_rt),
        .o_undef   (w_undef_op)
    );

    assign w_dec_wreg = (w_opcode == OP_JAL) ? '1 :
                        (w_opcode == OP_RTYPE) ? w_rd : w_rt;

    // Only a load already in EX with a nonzero target can starve the ID instruction.
    assign w_hazard = id_valid && r_ex_valid && r_ex.mem_r && (r_wreg != '0) &&
                      ((w_uses_rs && (w_rs == r_wreg)) || (w_uses_rt && (w_rt == r_wreg)));

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ex_nxt       = r_ex;
        w_ex_valid_nxt = r_ex_valid;
        w_wreg_nxt     = r_wreg;
        w_undef_nxt    = r_undef;
        w_undef_op_nxt = r_undef_op;
        w_we           = 1'b0;
        w_bubble       = 1'b0;

        if (branch_taken) begin
            w_we        = 1'b1;
            w_bubble    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = (r_state == ST_HALT) ? ST_HALT : ST_RUN;
        end else if (ex_stall_in) begin
            w_we = 1'b0;
        end else if (r_state == ST_HALT) begin
            w_bubble = 1'b1;
            if (undef_clr) begin
                w_state_nxt    = ST_RUN;
                w_undef_nxt    = 1'b0;
                w_undef_op_nxt = '0;
            end
        end else if (r_state == ST_LU_STALL) begin
            w_bubble = 1'b1;
            if (r_cnt <= CNT_W'(1)) begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_RUN;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end else if (!id_valid) begin
            w_we     = 1'b1;
            w_bubble = 1'b1;
        end else if (w_hazard) begin
            // The detection cycle is itself the first bubble.
            w_bubble    = 1'b1;
            w_cnt_nxt   = LU_RELOAD;
            w_state_nxt = (LU_STALLS > 1) ? ST_LU_STALL : ST_RUN;
        end else if (w_undef_op) begin
            w_bubble    = 1'b1;
            w_undef_nxt = 1'b1;
            if (!r_undef) begin
                w_undef_op_nxt = w_opcode;
            end
            w_state_nxt = ST_HALT;
        end else begin
            w_we           = 1'b1;
            w_ex_nxt       = w_dec;
            w_ex_valid_nxt = 1'b1;
            w_wreg_nxt     = w_dec_wreg;
        end

        if (w_bubble) begin
            w_ex_nxt       = '0;
            w_ex_valid_nxt = 1'b0;
            w_wreg_nxt     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_ex       <= '0;
            r_ex_valid <= 1'b0;
            r_wreg     <= '0;
            r_undef    <= 1'b0;
            r_undef_op <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ex       <= w_ex_nxt;
            r_ex_valid <= w_ex_valid_nxt;
            r_wreg     <= w_wreg_nxt;
            r_undef    <= w_undef_nxt;
            r_undef_op <= w_undef_op_nxt;
        end
    end

    assign pc_we         = rst_n && w_we;
    assign ifid_we       = rst_n && w_we;
    assign ifid_flush    = branch_taken;
    assign ex_valid      = r_ex_valid;
    assign ex_reg_write  = r_ex.reg_write;
    assign ex_alu_src    = r_ex.alu_src;
    assign ex_reg_dst    = r_ex.reg_dst;
    assign ex_mem_w      = r_ex.mem_w;
    assign ex_mem_r      = r_ex.mem_r;
    assign ex_mem_to_reg = r_ex.mem_to_reg;
    assign ex_jump       = r_ex.jump;
    assign ex_alu_op     = r_ex.alu_op;
    assign ex_branch     = r_ex.branch;
    assign ex_wreg       = r_wreg;
    assign undef_inst    = r_undef;
    assign undef_opcode  = r_undef_op;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two instances (1 and 3 load-use bubbles) on shared stimulus,
// checked each cycle against a remaining-bubble-count model plus literal spot checks.
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, branch_taken, ex_stall_in, undef_clr;
    logic [31:0] id_inst;

    logic [1:0]      pc_we, ifid_we, ifid_flush, ex_valid, ex_reg_write, ex_alu_src, ex_reg_dst;
    logic [1:0]      ex_mem_w, ex_mem_r, ex_mem_to_reg, ex_jump, undef_inst;
    logic [1:0][1:0] ex_alu_op, ex_branch;
    logic [1:0][4:0] ex_wreg;
    logic [1:0][5:0] undef_opcode;

    int n_vec = 0;
    int n_err = 0;

    // Model state per instance: bubbles still owed, halt, sticky flag, EX word
    // EX word: [16] valid, [15:5] {rw,alusrc,regdst,memw,memr,memtoreg,jump,aluop,branch}, [4:0] wreg
    int          m_n[2] = '{1, 3};
    int          m_left[2];
    bit          m_halt[2];
    bit          m_flag[2];
    logic [5:0]  m_opc[2];
    logic [16:0] m_ex[2];

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.INST_W(32), .REG_AW(5), .LU_STALLS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
        .branch_taken(branch_taken), .ex_stall_in(ex_stall_in), .undef_clr(undef_clr),
        .pc_we(pc_we[0]), .ifid_we(ifid_we[0]), .ifid_flush(ifid_flush[0]), .ex_valid(ex_valid[0]),
        .ex_reg_write(ex_reg_write[0]), .ex_alu_src(ex_alu_src[0]), .ex_reg_dst(ex_reg_dst[0]),
        .ex_mem_w(ex_mem_w[0]), .ex_mem_r(ex_mem_r[0]), .ex_mem_to_reg(ex_mem_to_reg[0]),
        .ex_jump(ex_jump[0]), .ex_alu_op(ex_alu_op[0]), .ex_branch(ex_branch[0]),
        .ex_wreg(ex_wreg[0]), .undef_inst(undef_inst[0]), .undef_opcode(undef_opcode[0])
    );

    pipe_ctrl_unit #(.INST_W(32), .REG_AW(5), .LU_STALLS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
        .branch_taken(branch_taken), .ex_stall_in(ex_stall_in), .undef_clr(undef_clr),
        .pc_we(pc_we[1]), .ifid_we(ifid_we[1]), .ifid_flush(ifid_flush[1]), .ex_valid(ex_valid[1]),
        .ex_reg_write(ex_reg_write[1]), .ex_alu_src(ex_alu_src[1]), .ex_reg_dst(ex_reg_dst[1]),
        .ex_mem_w(ex_mem_w[1]), .ex_mem_r(ex_mem_r[1]), .ex_mem_to_reg(ex_mem_to_reg[1]),
        .ex_jump(ex_jump[1]), .ex_alu_op(ex_alu_op[1]), .ex_branch(ex_branch[1]),
        .ex_wreg(ex_wreg[1]), .undef_inst(undef_inst[1]), .undef_opcode(undef_opcode[1])
    );

    function automatic logic [10:0] f_ctrl(input logic [5:0] op);
        case (op)
            6'b000000: return 11'b1_0_1_0_0_0_0_00_00;
            6'b001000: return 11'b1_1_0_0_0_0_0_01_00;
            6'b001101: return 11'b1_1_0_0_0_0_0_10_00;
            6'b100011, 6'b100100: return 11'b1_1_0_0_1_1_0_01_00;
            6'b101011, 6'b101100: return 11'b0_1_0_1_0_0_0_01_00;
            6'b000100: return 11'b0_0_0_0_0_0_0_00_01;
            6'b000101: return 11'b0_0_0_0_0_0_0_00_11;
            6'b000010: return 11'b0_0_0_0_0_0_1_00_00;
            6'b000011: return 11'b1_0_0_0_0_0_1_00_00;
            default:   return 11'b0;
        endcase
    endfunction

    function automatic bit f_defined(input logic [5:0] op);
        return op inside {6'b000000, 6'b001000, 6'b001101, 6'b100011, 6'b100100, 6'b101011,
                          6'b101100, 6'b000100, 6'b000101, 6'b000010, 6'b000011};
    endfunction

    function automatic bit f_hazard(input int k);
        logic [5:0] op;
        logic [4:0] w;
        bit         urs, urt;
        op  = id_inst[31:26];
        w   = m_ex[k][4:0];
        urs = !(op inside {6'b000010, 6'b000011});
        urt = op inside {6'b000000, 6'b000100, 6'b000101, 6'b101011, 6'b101100};
        return id_valid && m_ex[k][16] && m_ex[k][11] && (w != 5'd0) &&
               ((urs && id_inst[25:21] == w) || (urt && id_inst[20:16] == w));
    endfunction

    function automatic bit f_we(input int k);
        if (!rst_n) return 1'b0;
        if (branch_taken) return 1'b1;
        if (ex_stall_in || m_halt[k] || m_left[k] > 0) return 1'b0;
        if (!id_valid) return 1'b1;
        return !(f_hazard(k) || !f_defined(id_inst[31:26]));
    endfunction

    task automatic model_step(input int k);
        logic [5:0] op;
        logic [4:0] wr;
        op = id_inst[31:26];
        if (!rst_n) begin
            m_left[k] = 0; m_halt[k] = 0; m_flag[k] = 0; m_opc[k] = 0; m_ex[k] = 0;
        end else if (branch_taken) begin
            m_ex[k] = 0; m_left[k] = 0;
        end else if (ex_stall_in) begin
            m_left[k] = m_left[k];
        end else if (m_halt[k]) begin
            m_ex[k] = 0;
            if (undef_clr) begin
                m_halt[k] = 0; m_flag[k] = 0; m_opc[k] = 0;
            end
        end else if (m_left[k] > 0) begin
            m_ex[k] = 0; m_left[k] = m_left[k] - 1;
        end else if (!id_valid) begin
            m_ex[k] = 0;
        end else if (f_hazard(k)) begin
            m_ex[k] = 0; m_left[k] = m_n[k] - 1;
        end else if (!f_defined(op)) begin
            m_ex[k] = 0; m_halt[k] = 1;
            if (!m_flag[k]) m_opc[k] = op;
            m_flag[k] = 1;
        end else begin
            wr = (op == 6'b000011) ? 5'd31 : (op == 6'b000000) ? id_inst[15:11] : id_inst[20:16];
            m_ex[k] = {1'b1, f_ctrl(op), wr};
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    function automatic logic [16:0] dut_word(input int k);
        return {ex_valid[k], ex_reg_write[k], ex_alu_src[k], ex_reg_dst[k], ex_mem_w[k], ex_mem_r[k],
                ex_mem_to_reg[k], ex_jump[k], ex_alu_op[k], ex_branch[k], ex_wreg[k]};
    endfunction

    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("ex_bundle", k, 32'(dut_word(k)), 32'(m_ex[k]));
            chk("pc_we", k, 32'(pc_we[k]), 32'(f_we(k)));
            chk("ifid_we", k, 32'(ifid_we[k]), 32'(f_we(k)));
            chk("ifid_flush", k, 32'(ifid_flush[k]), 32'(branch_taken));
            chk("undef_inst", k, 32'(undef_inst[k]), 32'(m_flag[k]));
            chk("undef_opcode", k, 32'(undef_opcode[k]), 32'(m_opc[k]));
            model_step(k);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; id_valid = 0; branch_taken = 0; ex_stall_in = 0; undef_clr = 0; id_inst = 0;
        cycle();
        cycle();
        rst_n = 1;
    endtask

    localparam logic [31:0] LW2  = 32'h8C22_0004;  // lw  $2, 4($1)
    localparam logic [31:0] ADD  = 32'h0044_1820;  // add $3, $2, $4
    localparam logic [31:0] LW0  = 32'h8C20_0004;  // lw  $0, 4($1)
    localparam logic [31:0] ADD0 = 32'h0004_1820;  // add $3, $0, $4
    localparam logic [31:0] BEQ  = 32'h1022_0003;
    localparam logic [31:0] UD1  = 32'hFC00_0000;
    localparam logic [31:0] UD2  = 32'hF400_0000;

    initial begin
        logic [5:0] ops[12];
        ops = '{6'b000000, 6'b001000, 6'b001101, 6'b100011, 6'b100100, 6'b101011,
                6'b101100, 6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b111111};

        do_reset();
        chk("reset_ex_valid", 0, 32'(ex_valid[0]), 32'd0);
        chk("reset_undef", 1, 32'(undef_inst[1]), 32'd0);

        // lw then dependent add
        id_inst = LW2; id_valid = 1;
        cycle();
        chk("lw_ex_valid", 0, 32'(ex_valid[0]), 32'd1);
        chk("lw_mem_r", 0, 32'(ex_mem_r[0]), 32'd1);
        chk("lw_mem_to_reg", 0, 32'(ex_mem_to_reg[0]), 32'd1);
        chk("lw_alu_src", 0, 32'(ex_alu_src[0]), 32'd1);
        chk("lw_alu_op", 0, 32'(ex_alu_op[0]), 32'd1);
        chk("lw_wreg", 0, 32'(ex_wreg[0]), 32'd2);
        id_inst = ADD;
        #1;
        chk("lu_pc_we", 0, 32'(pc_we[0]), 32'd0);
        chk("lu_ifid_we", 1, 32'(ifid_we[1]), 32'd0);
        cycle();
        chk("lu_bubble", 0, 32'(ex_valid[0]), 32'd0);
        chk("lu_bubble", 1, 32'(ex_valid[1]), 32'd0);
        chk("lu1_resume_we", 0, 32'(pc_we[0]), 32'd1);
        chk("lu3_still_we", 1, 32'(pc_we[1]), 32'd0);
        cycle();
        chk("lu1_add_valid", 0, 32'(ex_valid[0]), 32'd1);
        chk("lu1_add_reg_dst", 0, 32'(ex_reg_dst[0]), 32'd1);
        chk("lu1_add_wreg", 0, 32'(ex_wreg[0]), 32'd3);
        chk("lu3_bubble2", 1, 32'(ex_valid[1]), 32'd0);
        cycle();
        chk("lu3_bubble3", 1, 32'(ex_valid[1]), 32'd0);
        cycle();
        chk("lu3_add_valid", 1, 32'(ex_valid[1]), 32'd1);
        chk("lu3_add_wreg", 1, 32'(ex_wreg[1]), 32'd3);

        // load to $0 never stalls
        do_reset();
        id_inst = LW0; id_valid = 1;
        cycle();
        id_inst = ADD0;
        #1;
        chk("r0_no_stall", 0, 32'(pc_we[0]), 32'd1);
        chk("r0_no_stall", 1, 32'(pc_we[1]), 32'd1);
        cycle();
        chk("r0_add_valid", 1, 32'(ex_valid[1]), 32'd1);

        // branch flush during a load-use stall
        do_reset();
        id_inst = LW2; id_valid = 1;
        cycle();
        id_inst = ADD;
        cycle();
        branch_taken = 1; id_inst = BEQ;
        #1;
        chk("br_flush", 1, 32'(ifid_flush[1]), 32'd1);
        chk("br_pc_we", 1, 32'(pc_we[1]), 32'd1);
        cycle();
        branch_taken = 0;
        #1;
        chk("br_bubble", 1, 32'(ex_valid[1]), 32'd0);
        chk("br_branch", 1, 32'(ex_branch[1]), 32'd0);
        chk("br_run_we", 1, 32'(pc_we[1]), 32'd1);
        cycle();
        chk("beq_branch", 1, 32'(ex_branch[1]), 32'd1);

        // undefined opcode halt and clear
        do_reset();
        id_inst = UD1; id_valid = 1;
        #1;
        chk("ud_pc_we", 0, 32'(pc_we[0]), 32'd0);
        cycle();
        chk("ud_flag", 0, 32'(undef_inst[0]), 32'd1);
        chk("ud_opcode", 0, 32'(undef_opcode[0]), 32'h3F);
        id_inst = UD2;
        repeat (3) cycle();
        chk("ud_opcode_kept", 1, 32'(undef_opcode[1]), 32'h3F);
        chk("ud_halt_we", 1, 32'(pc_we[1]), 32'd0);
        undef_clr = 1; id_inst = ADD;
        cycle();
        undef_clr = 0;
        #1;
        chk("ud_clr_flag", 0, 32'(undef_inst[0]), 32'd0);
        chk("ud_clr_opcode", 0, 32'(undef_opcode[0]), 32'd0);
        chk("ud_clr_we", 0, 32'(pc_we[0]), 32'd1);
        cycle();

        // memory wait in the middle of a 3-bubble stall
        do_reset();
        id_inst = LW2; id_valid = 1;
        cycle();
        id_inst = ADD;
        cycle();
        cycle();
        ex_stall_in = 1;
        #1;
        chk("hold_pc_we", 1, 32'(pc_we[1]), 32'd0);
        repeat (4) cycle();
        chk("hold_ex1", 0, 32'(ex_valid[0]), 32'd1);
        chk("hold_ex3", 1, 32'(ex_valid[1]), 32'd0);
        ex_stall_in = 0;
        cycle();
        chk("resume_bubble", 1, 32'(ex_valid[1]), 32'd0);
        cycle();
        chk("resume_add", 1, 32'(ex_valid[1]), 32'd1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(11)];
            if (op == 6'b111111 && $urandom_range(1) == 0) op = 6'b010001;
            id_inst      = {op, 3'b000, 2'($urandom_range(3)), 3'b000, 2'($urandom_range(3)),
                            3'b000, 2'($urandom_range(3)), 11'($urandom)};
            id_valid     = ($urandom_range(99) < 85);
            branch_taken = ($urandom_range(15) == 0);
            ex_stall_in  = ($urandom_range(7) == 0);
            undef_clr    = ($urandom_range(3) == 0);
            rst_n        = ($urandom_range(199) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
